top_robertsons: RTL and testbench

//   Sequential signed (two's-complement) multiplier using Robertson's add/shift algorithm.
//   - Multiplies an N-bit multiplier by an N-bit multiplicand and produces a 2N-bit product.
//   - Processes one multiplier bit per clock.
//   - Free-running: it re-samples its operands after every result and needs no start strobe.
//   - Standalone arithmetic block, top of its own hierarchy.

---
 rtl/robertsons_pkg.sv | 18 +
 rtl/robertsons_datapath.sv | 56 +++++
 rtl/top_robertsons.sv | 73 +++++++
 tb/tb_top_robertsons.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/robertsons_pkg.sv
// Shared definitions for the Robertson's sequential signed multiplier.
package robertsons_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int count_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int COUNT_W = count_w(N_DEFAULT);

endpackage

// File: rtl/robertsons_datapath.sv
// A/Q/M registers, N+1-bit add/subtract, arithmetic shift and product register.
module robertsons_datapath
  import robertsons_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic                  last,
  input  logic signed [N-1:0]   multiplier,
  input  logic signed [N-1:0]   multiplicand,
  output logic signed [2*N-1:0] product
);

  logic signed [N:0]   a;
  logic        [N-1:0] q;
  logic signed [N-1:0] m;

  logic signed [N:0]   m_ext;
  logic signed [N:0]   sum;
  logic signed [N:0]   a_next;
  logic        [N-1:0] q_next;

  // The final step subtracts M: the multiplier's sign bit carries weight -2^(N-1).
  always_comb begin
    m_ext = {m[N-1], m};
    sum   = a;
    if (q[0]) begin
      sum = last ? (a - m_ext) : (a + m_ext);
    end
    a_next = {sum[N], sum[N:1]};
    q_next = {sum[0], q[N-1:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a       <= '0;
      q       <= '0;
      m       <= '0;
      product <= '0;
    end else if (load) begin
      a <= '0;
      q <= multiplier;
      m <= multiplicand;
    end else if (step) begin
      a <= a_next;
      q <= q_next;
      if (last) begin
        product <= {a_next[N-1:0], q_next};
      end
    end
  end

endmodule

// File: rtl/top_robertsons.sv
// Free-running Robertson's signed multiplier: load, N shift/add steps, one done cycle.
module top_robertsons
  import robertsons_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic signed [N-1:0]   multiplier,
  input  logic signed [N-1:0]   multiplicand,
  output logic signed [2*N-1:0] product,
  output logic                  done
);

  localparam int CW = count_w(N);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic          load;
  logic          step;
  logic          last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        count <= '0;
      end else if (state == RUN) begin
        count <= count + CW'(1);
      end
    end
  end

  assign last = (state == RUN) && (count == CW'(N - 1));

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        load       = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign done = (state == DONE);

  robertsons_datapath #(.N(N)) u_datapath (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .step         (step),
    .last         (last),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .product      (product)
  );

endmodule

// File: tb/tb_top_robertsons.sv
// Self-checking bench for top_robertsons: spec vectors, random operands, mid-run corners.
module tb_top_robertsons;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  multiplier;
  logic [N-1:0]  multiplicand;
  logic [2*N-1:0] product;
  logic          done;

  int errors = 0;
  int checks = 0;

  top_robertsons #(.N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .product      (product),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  mq;
    logic [7:0]  mm;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [8];

  // Reference: plain signed integer multiplication, truncated to the product width.
  function automatic logic [15:0] model(input logic [7:0] q, input logic [7:0] m);
    int p;
    p = int'($signed(q)) * int'($signed(m));
    return p[15:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for the negedge where done is high; reports cycles and done at first negedge.
  task automatic wait_done(output int cyc, output logic first_done);
    cyc = 0;
    first_done = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) first_done = done;
    end while (!done && cyc < 40);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_done: timeout after %0d cycles, done=%0b expected 1", cyc, done);
    end
  endtask

  initial begin
    int          cyc;
    logic        fd;
    logic [7:0]  rq;
    logic [7:0]  rm;
    logic [15:0] last_exp;

    tbl[0] = '{8'd5,   8'd6,   16'h001E};
    tbl[1] = '{8'hF9,  8'h08,  16'hFFC8};
    tbl[2] = '{8'd5,   8'hFA,  16'hFFE2};
    tbl[3] = '{8'hFB,  8'hFA,  16'h001E};
    tbl[4] = '{8'hF7,  8'hFC,  16'h0024};
    tbl[5] = '{8'h80,  8'h80,  16'h4000};
    tbl[6] = '{8'h80,  8'h7F,  16'hC080};
    tbl[7] = '{8'h00,  8'hFF,  16'h0000};

    multiplier   = 8'd5;
    multiplicand = 8'd6;
    reset        = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_product", 32'(product), 32'h0);
    check("reset_done", 32'(done), 32'h0);

    reset = 1'b1;
    wait_done(cyc, fd);
    check("first_latency", cyc, 32'd9);
    check("first_product", 32'(product), 32'h001E);

    for (int i = 0; i < 8; i++) begin
      multiplier   = tbl[i].mq;
      multiplicand = tbl[i].mm;
      wait_done(cyc, fd);
      check($sformatf("vec%0d_product", i), 32'(product), 32'(tbl[i].exp));
      check($sformatf("vec%0d_period", i), cyc, 32'd10);
      check($sformatf("vec%0d_done_pulse", i), 32'(fd), 32'h0);
    end

    last_exp = 16'h0000;
    for (int i = 0; i < 30; i++) begin
      rq = 8'($urandom);
      rm = 8'($urandom);
      if (i == 0) rq = 8'h7F;
      if (i == 1) rm = 8'h80;
      multiplier   = rq;
      multiplicand = rm;
      wait_done(cyc, fd);
      last_exp = model(rq, rm);
      check($sformatf("rand%0d_%0h_x_%0h", i, rq, rm), 32'(product), 32'(last_exp));
    end

    // Operands changed while running: current result keeps old operands.
    multiplier   = 8'd100;
    multiplicand = 8'hC3;
    repeat (4) @(negedge clk);
    check("midrun_product_held", 32'(product), 32'(last_exp));
    check("midrun_done_low", 32'(done), 32'h0);
    multiplier   = 8'hF0;
    multiplicand = 8'd9;
    wait_done(cyc, fd);
    check("midrun_old_operands", 32'(product), 32'(model(8'd100, 8'hC3)));
    wait_done(cyc, fd);
    check("midrun_new_operands", 32'(product), 32'(model(8'hF0, 8'd9)));

    // Reset pulsed mid-run clears at once, then a full computation follows.
    multiplier   = 8'h7F;
    multiplicand = 8'h81;
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_product", 32'(product), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    @(negedge clk);
    check("abort_done_held", 32'(done), 32'h0);
    reset = 1'b1;
    wait_done(cyc, fd);
    check("abort_relatency", cyc, 32'd9);
    check("abort_product_after", 32'(product), 32'(model(8'h7F, 8'h81)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
